// File: rtl/mlp_cmd_pkg.sv
// Shared opcodes, reply codes and FSM state encoding for the MLP command sequencer.
package mlp_cmd_pkg;

  // Host command opcodes
  localparam logic [7:0] OP_WRITE_WEIGHTS = 8'h01;
  localparam logic [7:0] OP_WRITE_ACT     = 8'h02;
  localparam logic [7:0] OP_START         = 8'h03;
  localparam logic [7:0] OP_STATUS        = 8'h04;

  // Single-byte error replies
  localparam logic [7:0] REPLY_NO_WEIGHTS = 8'hE1;
  localparam logic [7:0] REPLY_TIMEOUT    = 8'hEE;

  // Reply lengths in bytes
  localparam logic [3:0] LEN_BYTE   = 4'd1;
  localparam logic [3:0] LEN_RESULT = 4'd8;

  // Sequencer states
  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_RX_WEIGHT = 3'd1,
    ST_RX_ACT_LO = 3'd2,
    ST_RX_ACT_HI = 3'd3,
    ST_RUN_WAIT  = 3'd4,
    ST_TX_RESULT = 3'd5,
    ST_TX_BYTE   = 3'd6
  } seq_state_e;

endpackage

// File: rtl/cmd_tx_serializer.sv
// Loads up to 8 reply bytes and shifts them out LSB-first over a valid/ready byte link.
module cmd_tx_serializer (
  input  logic        clk,
  input  logic        rst,
  input  logic        load_i,
  input  logic [63:0] data_i,
  input  logic [3:0]  len_i,
  input  logic        tx_ready_i,
  output logic        tx_valid_o,
  output logic [7:0]  tx_data_o,
  output logic        done_c_o
);

  logic [63:0] shift_q, shift_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        valid_q, valid_d;

  // Byte shift register, remaining-byte counter (bytes left minus one) and valid flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_q <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
    end
  end

  // Load when idle, advance one byte per accepted transfer
  always_comb begin
    shift_d = shift_q;
    cnt_d   = cnt_q;
    valid_d = valid_q;
    if (load_i && !valid_q) begin
      shift_d = data_i;
      cnt_d   = 3'(len_i - 4'd1);
      valid_d = 1'b1;
    end else if (valid_q && tx_ready_i) begin
      shift_d = {8'h00, shift_q[63:8]};
      if (cnt_q == 3'd0) begin
        valid_d = 1'b0;
      end else begin
        cnt_d = cnt_q - 3'd1;
      end
    end
  end

  assign tx_valid_o = valid_q;
  assign tx_data_o  = shift_q[7:0];
  assign done_c_o   = valid_q && tx_ready_i && (cnt_q == 3'd0);

endmodule

// File: rtl/mlp_cmd_sequencer.sv
// Byte-protocol command front-end: decodes UART command bytes into TPU bridge
// controls, supervises MLP runs and returns results/status over UART TX.
module mlp_cmd_sequencer
  import mlp_cmd_pkg::*;
#(
  parameter int unsigned N_WEIGHT_BYTES = 4,
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter logic [3:0]  MLP_IDLE_STATE = 4'd0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rx_valid,
  input  logic [7:0]         rx_data,
  output logic               rx_ready,
  output logic               tx_valid,
  output logic [7:0]         tx_data,
  input  logic               tx_ready,
  output logic               ctrl_wf_push_col0,
  output logic               ctrl_wf_push_col1,
  output logic [7:0]         ctrl_wf_data_in,
  output logic               ctrl_wf_reset,
  output logic               ctrl_init_act_valid,
  output logic [15:0]        ctrl_init_act_data,
  output logic               ctrl_start_mlp,
  output logic               ctrl_weights_ready,
  input  logic [3:0]         mlp_state,
  input  logic signed [31:0] mlp_acc0,
  input  logic signed [31:0] mlp_acc1,
  output logic               cmd_err
);

  localparam int unsigned WCNT_W   = $clog2(N_WEIGHT_BYTES);
  localparam int unsigned HALF_WB  = N_WEIGHT_BYTES / 2;
  localparam int unsigned TMO_W    = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  seq_state_e        state_q, state_d;
  logic [WCNT_W-1:0] wcnt_q, wcnt_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  logic              seen_q, seen_d;
  logic [7:0]        act_lo_q, act_lo_d;
  logic [15:0]       act_data_q, act_data_d;
  logic              act_valid_q, act_valid_d;
  logic              push0_q, push0_d;
  logic              push1_q, push1_d;
  logic [7:0]        wf_data_q, wf_data_d;
  logic              wf_reset_q, wf_reset_d;
  logic              start_q, start_d;
  logic              wready_q, wready_d;
  logic              err_q, err_d;
  logic              rx_ready_q, rx_ready_d;

  logic              rx_fire_c;
  logic              ser_load_c;
  logic [63:0]       ser_data_c;
  logic [3:0]        ser_len_c;
  logic              ser_done_c;

  assign rx_fire_c = rx_valid && rx_ready_q;

  // Reply byte serializer shared by result, status and error replies
  cmd_tx_serializer u_tx (
    .clk        (clk),
    .rst        (rst),
    .load_i     (ser_load_c),
    .data_i     (ser_data_c),
    .len_i      (ser_len_c),
    .tx_ready_i (tx_ready),
    .tx_valid_o (tx_valid),
    .tx_data_o  (tx_data),
    .done_c_o   (ser_done_c)
  );

  // State and registered control outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      wcnt_q      <= '0;
      tmo_q       <= '0;
      seen_q      <= 1'b0;
      act_lo_q    <= '0;
      act_data_q  <= '0;
      act_valid_q <= 1'b0;
      push0_q     <= 1'b0;
      push1_q     <= 1'b0;
      wf_data_q   <= '0;
      wf_reset_q  <= 1'b0;
      start_q     <= 1'b0;
      wready_q    <= 1'b0;
      err_q       <= 1'b0;
      rx_ready_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      wcnt_q      <= wcnt_d;
      tmo_q       <= tmo_d;
      seen_q      <= seen_d;
      act_lo_q    <= act_lo_d;
      act_data_q  <= act_data_d;
      act_valid_q <= act_valid_d;
      push0_q     <= push0_d;
      push1_q     <= push1_d;
      wf_data_q   <= wf_data_d;
      wf_reset_q  <= wf_reset_d;
      start_q     <= start_d;
      wready_q    <= wready_d;
      err_q       <= err_d;
      rx_ready_q  <= rx_ready_d;
    end
  end

  // Command decode, run supervision and reply scheduling
  always_comb begin
    state_d     = state_q;
    wcnt_d      = wcnt_q;
    tmo_d       = tmo_q;
    seen_d      = seen_q;
    act_lo_d    = act_lo_q;
    act_data_d  = act_data_q;
    act_valid_d = 1'b0;
    push0_d     = 1'b0;
    push1_d     = 1'b0;
    wf_data_d   = wf_data_q;
    wf_reset_d  = 1'b0;
    start_d     = 1'b0;
    wready_d    = wready_q;
    err_d       = 1'b0;
    ser_load_c  = 1'b0;
    ser_data_c  = '0;
    ser_len_c   = LEN_BYTE;

    unique case (state_q)
      ST_IDLE: begin
        if (rx_fire_c) begin
          unique case (rx_data)
            OP_WRITE_WEIGHTS: begin
              wf_reset_d = 1'b1;
              wready_d   = 1'b0;
              wcnt_d     = '0;
              state_d    = ST_RX_WEIGHT;
            end
            OP_WRITE_ACT: begin
              state_d = ST_RX_ACT_LO;
            end
            OP_START: begin
              if (!wready_q) begin
                ser_load_c = 1'b1;
                ser_data_c = 64'(REPLY_NO_WEIGHTS);
                err_d      = 1'b1;
                state_d    = ST_TX_BYTE;
              end else begin
                start_d = 1'b1;
                tmo_d   = '0;
                seen_d  = 1'b0;
                state_d = ST_RUN_WAIT;
              end
            end
            OP_STATUS: begin
              ser_load_c = 1'b1;
              ser_data_c = 64'({wready_q, 3'b000, mlp_state});
              state_d    = ST_TX_BYTE;
            end
            default: begin
              err_d = 1'b1;
            end
          endcase
        end
      end

      ST_RX_WEIGHT: begin
        if (rx_fire_c) begin
          wf_data_d = rx_data;
          if (wcnt_q < WCNT_W'(HALF_WB)) begin
            push0_d = 1'b1;
          end else begin
            push1_d = 1'b1;
          end
          if (wcnt_q == WCNT_W'(N_WEIGHT_BYTES - 1)) begin
            wready_d = 1'b1;
            state_d  = ST_IDLE;
          end else begin
            wcnt_d = wcnt_q + WCNT_W'(1);
          end
        end
      end

      ST_RX_ACT_LO: begin
        if (rx_fire_c) begin
          act_lo_d = rx_data;
          state_d  = ST_RX_ACT_HI;
        end
      end

      ST_RX_ACT_HI: begin
        if (rx_fire_c) begin
          act_data_d  = {rx_data, act_lo_q};
          act_valid_d = 1'b1;
          state_d     = ST_IDLE;
        end
      end

      ST_RUN_WAIT: begin
        if (mlp_state != MLP_IDLE_STATE) begin
          seen_d = 1'b1;
        end
        if (seen_q && (mlp_state == MLP_IDLE_STATE)) begin
          ser_load_c = 1'b1;
          ser_data_c = {mlp_acc1, mlp_acc0};
          ser_len_c  = LEN_RESULT;
          state_d    = ST_TX_RESULT;
        end else if (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
          ser_load_c = 1'b1;
          ser_data_c = 64'(REPLY_TIMEOUT);
          err_d      = 1'b1;
          state_d    = ST_TX_BYTE;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end

      ST_TX_RESULT, ST_TX_BYTE: begin
        if (ser_done_c) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    rx_ready_d = (state_d == ST_IDLE)      || (state_d == ST_RX_WEIGHT) ||
                 (state_d == ST_RX_ACT_LO) || (state_d == ST_RX_ACT_HI);
  end

  assign rx_ready            = rx_ready_q;
  assign ctrl_wf_push_col0   = push0_q;
  assign ctrl_wf_push_col1   = push1_q;
  assign ctrl_wf_data_in     = wf_data_q;
  assign ctrl_wf_reset       = wf_reset_q;
  assign ctrl_init_act_valid = act_valid_q;
  assign ctrl_init_act_data  = act_data_q;
  assign ctrl_start_mlp      = start_q;
  assign ctrl_weights_ready  = wready_q;
  assign cmd_err             = err_q;

endmodule

// File: tb/tb_mlp_cmd_sequencer.sv
// Directed + randomized bench for mlp_cmd_sequencer with a byte-level reference model.
module tb_mlp_cmd_sequencer;
  import mlp_cmd_pkg::*;

  localparam int unsigned NWB = 4;
  localparam int unsigned TMO = 16;

  typedef logic [7:0] byte_q_t[$];

  logic               clk = 1'b0;
  logic               rst;
  logic               rx_valid;
  logic [7:0]         rx_data;
  logic               rx_ready;
  logic               tx_valid;
  logic [7:0]         tx_data;
  logic               tx_ready;
  logic               ctrl_wf_push_col0;
  logic               ctrl_wf_push_col1;
  logic [7:0]         ctrl_wf_data_in;
  logic               ctrl_wf_reset;
  logic               ctrl_init_act_valid;
  logic [15:0]        ctrl_init_act_data;
  logic               ctrl_start_mlp;
  logic               ctrl_weights_ready;
  logic [3:0]         mlp_state;
  logic signed [31:0] mlp_acc0;
  logic signed [31:0] mlp_acc1;
  logic               cmd_err;

  int checks = 0;
  int errors = 0;

  byte_q_t     col0_got, col1_got, tx_got;
  int          wf_reset_n = 0, start_n = 0, err_n = 0, act_n = 0;
  logic [15:0] act_last = '0;
  logic        stall_prev = 1'b0;
  logic [7:0]  stall_data = '0;

  mlp_cmd_sequencer #(
    .N_WEIGHT_BYTES (NWB),
    .TIMEOUT_CYCLES (TMO),
    .MLP_IDLE_STATE (4'd0)
  ) dut (
    .clk                 (clk),
    .rst                 (rst),
    .rx_valid            (rx_valid),
    .rx_data             (rx_data),
    .rx_ready            (rx_ready),
    .tx_valid            (tx_valid),
    .tx_data             (tx_data),
    .tx_ready            (tx_ready),
    .ctrl_wf_push_col0   (ctrl_wf_push_col0),
    .ctrl_wf_push_col1   (ctrl_wf_push_col1),
    .ctrl_wf_data_in     (ctrl_wf_data_in),
    .ctrl_wf_reset       (ctrl_wf_reset),
    .ctrl_init_act_valid (ctrl_init_act_valid),
    .ctrl_init_act_data  (ctrl_init_act_data),
    .ctrl_start_mlp      (ctrl_start_mlp),
    .ctrl_weights_ready  (ctrl_weights_ready),
    .mlp_state           (mlp_state),
    .mlp_acc0            (mlp_acc0),
    .mlp_acc1            (mlp_acc1),
    .cmd_err             (cmd_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_q(input string tag, input byte_q_t got, input byte_q_t exp);
    chk({tag, "_len"}, 64'(got.size()), 64'(exp.size()));
    foreach (exp[i]) begin
      chk($sformatf("%s_%0d", tag, i), 64'((i < got.size()) ? got[i] : 8'hxx), 64'(exp[i]));
    end
  endtask

  // Random transmitter back-pressure, changed just after each rising edge
  initial begin
    tx_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1 tx_ready = 1'($urandom_range(0, 1));
    end
  end

  // Output monitor: pulses, pushes, accepted TX bytes and stall stability
  always @(negedge clk) begin
    if (!rst) begin
      if (ctrl_wf_push_col0) col0_got.push_back(ctrl_wf_data_in);
      if (ctrl_wf_push_col1) col1_got.push_back(ctrl_wf_data_in);
      if (ctrl_wf_reset) wf_reset_n++;
      if (ctrl_start_mlp) start_n++;
      if (cmd_err) err_n++;
      if (ctrl_init_act_valid) begin
        act_n++;
        act_last = ctrl_init_act_data;
      end
      if (stall_prev) begin
        chk("tx_hold_valid", 64'(tx_valid), 64'd1);
        chk("tx_hold_data", 64'(tx_data), 64'(stall_data));
      end
      if (tx_valid && tx_ready) tx_got.push_back(tx_data);
      stall_prev = tx_valid && !tx_ready;
      stall_data = tx_data;
    end else begin
      stall_prev = 1'b0;
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = b;
    while (!rx_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk($sformatf("rx_accept_%02h", b), 64'(rx_ready), 64'd1);
    @(posedge clk);
    #1 rx_valid = 1'b0;
  endtask

  task automatic wait_tx(input int n, input string tag);
    int k = 0;
    while (tx_got.size() < n && k < 400) begin
      @(negedge clk);
      k++;
    end
    idle(3);
    chk({tag, "_tx_count"}, 64'(tx_got.size()), 64'(n));
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_rx_ready"}, 64'(rx_ready), 64'd0);
    chk({tag, "_tx_valid"}, 64'(tx_valid), 64'd0);
    chk({tag, "_wready"}, 64'(ctrl_weights_ready), 64'd0);
    chk({tag, "_pulses"}, 64'({ctrl_wf_push_col0, ctrl_wf_push_col1, ctrl_wf_reset,
                               ctrl_init_act_valid, ctrl_start_mlp, cmd_err}), 64'd0);
    chk({tag, "_act_data"}, 64'(ctrl_init_act_data), 64'd0);
  endtask

  // Loads a full weight set and checks column split and ready handshake
  task automatic write_weights(input byte_q_t w, input string tag);
    byte_q_t e0, e1;
    int r0;
    col0_got.delete();
    col1_got.delete();
    r0 = wf_reset_n;
    send_byte(OP_WRITE_WEIGHTS);
    chk({tag, "_wready_cleared"}, 64'(ctrl_weights_ready), 64'd0);
    foreach (w[i]) begin
      send_byte(w[i]);
      if (i < NWB / 2) e0.push_back(w[i]);
      else e1.push_back(w[i]);
    end
    idle(2);
    chk({tag, "_wf_reset_pulses"}, 64'(wf_reset_n - r0), 64'd1);
    chk_q({tag, "_col0"}, col0_got, e0);
    chk_q({tag, "_col1"}, col1_got, e1);
    chk({tag, "_wready_set"}, 64'(ctrl_weights_ready), 64'd1);
  endtask

  task automatic write_act(input logic [15:0] a, input string tag);
    int a0 = act_n;
    send_byte(OP_WRITE_ACT);
    send_byte(8'(a % 256));
    send_byte(8'(a / 256));
    idle(3);
    chk({tag, "_act_pulses"}, 64'(act_n - a0), 64'd1);
    chk({tag, "_act_pulsed_data"}, 64'(act_last), 64'(a));
    chk({tag, "_act_held"}, 64'(ctrl_init_act_data), 64'(a));
  endtask

  // One full run: mlp goes busy for some cycles, result bytes must be little-endian acc0 then acc1
  task automatic run_mlp(input logic [31:0] a0, input logic [31:0] a1, input int busy, input string tag);
    byte_q_t exp;
    int s0 = start_n;
    int e0 = err_n;
    tx_got.delete();
    mlp_acc0 = a0;
    mlp_acc1 = a1;
    send_byte(OP_START);
    @(negedge clk);
    mlp_state = 4'd3;
    repeat (busy) @(negedge clk);
    mlp_state = 4'd0;
    idle(2);
    mlp_acc0 = $urandom;
    mlp_acc1 = $urandom;
    for (int i = 0; i < 4; i++) exp.push_back(8'((a0 >> (8 * i)) & 32'hFF));
    for (int i = 0; i < 4; i++) exp.push_back(8'((a1 >> (8 * i)) & 32'hFF));
    wait_tx(8, tag);
    chk({tag, "_start_pulses"}, 64'(start_n - s0), 64'd1);
    chk({tag, "_no_err"}, 64'(err_n - e0), 64'd0);
    chk_q({tag, "_bytes"}, tx_got, exp);
  endtask

  task automatic status(input logic [3:0] st, input logic wr, input string tag);
    byte_q_t exp;
    tx_got.delete();
    mlp_state = st;
    send_byte(OP_STATUS);
    exp.push_back({wr, 3'b000, st});
    wait_tx(1, tag);
    chk_q({tag, "_reply"}, tx_got, exp);
    mlp_state = 4'd0;
  endtask

  // Watchdog so the bench can never hang
  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not complete, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    byte_q_t w, exp;
    int e0, s0, k;

    rst       = 1'b1;
    rx_valid  = 1'b0;
    rx_data   = '0;
    mlp_state = 4'd0;
    mlp_acc0  = '0;
    mlp_acc1  = '0;
    #1;
    check_reset_outputs("por");
    idle(3);
    rst = 1'b0;

    // START before any weights: E1 reply, error pulse, no start
    tx_got.delete();
    e0 = err_n;
    s0 = start_n;
    send_byte(OP_START);
    exp = {REPLY_NO_WEIGHTS};
    wait_tx(1, "nowt");
    chk_q("nowt_reply", tx_got, exp);
    chk("nowt_err_pulses", 64'(err_n - e0), 64'd1);
    chk("nowt_no_start", 64'(start_n - s0), 64'd0);

    // Weights: directed then random
    w = {8'h11, 8'h22, 8'h33, 8'h44};
    write_weights(w, "wt_dir");
    w = {8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom)};
    write_weights(w, "wt_rnd");

    // Activation: directed then random
    write_act(16'h1234, "act_dir");
    write_act(16'($urandom), "act_rnd");

    // Runs with random back-pressure
    run_mlp(32'h0000_0102, 32'hFFFF_FFFF, 18 - 8, "run_dir");
    run_mlp($urandom, $urandom, int'($urandom_range(2, 10)), "run_rnd");

    status(4'($urandom_range(1, 15)), 1'b1, "stat_busy");

    // Timeout: mlp never leaves idle
    tx_got.delete();
    e0 = err_n;
    s0 = start_n;
    mlp_state = 4'd0;
    send_byte(OP_START);
    k = 0;
    while (!tx_valid && k < 200) begin
      @(negedge clk);
      k++;
    end
    chk("tmo_latency", 64'(k - 1), 64'(TMO));
    exp = {REPLY_TIMEOUT};
    wait_tx(1, "tmo");
    chk_q("tmo_reply", tx_got, exp);
    chk("tmo_err_pulses", 64'(err_n - e0), 64'd1);
    chk("tmo_start_pulses", 64'(start_n - s0), 64'd1);
    status(4'd0, 1'b1, "stat_after_tmo");

    // Reset in the middle of a weight load
    send_byte(OP_WRITE_WEIGHTS);
    send_byte(8'hA5);
    send_byte(8'h5A);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check_reset_outputs("mid_rst");
    idle(2);
    rst = 1'b0;

    // Unknown opcode: consumed, error pulse, no reply
    tx_got.delete();
    e0 = err_n;
    send_byte(8'h07);
    idle(10);
    chk("badop_err_pulses", 64'(err_n - e0), 64'd1);
    chk("badop_no_reply", 64'(tx_got.size()), 64'd0);
    chk("badop_still_idle", 64'(rx_ready), 64'd1);

    status(4'd0, 1'b0, "stat_after_rst");

    idle(5);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
